// File: rtl/tone_synth_if.sv
// Frequency-request handshake and sample-stream signals of the tone synthesizer.
// The master side drives requests and sample strobes; the slave side is the synthesizer.
interface tone_synth_if #(
  parameter int SIG_WIDTH = 9,
  parameter int WIDTH     = 32
);
  logic [WIDTH-1:0]            f_in;
  logic                        f_in_valid;
  logic                        f_ready_out;
  logic                        sample_tick_in;
  logic                        enable_in;
  logic [1:0]                  wave_sel_in;
  logic signed [SIG_WIDTH-1:0] sig_out;
  logic                        sig_out_valid;

  modport master (
    output f_in, f_in_valid, sample_tick_in, enable_in, wave_sel_in,
    input  f_ready_out, sig_out, sig_out_valid
  );

  modport slave (
    input  f_in, f_in_valid, sample_tick_in, enable_in, wave_sel_in,
    output f_ready_out, sig_out, sig_out_valid
  );
endinterface

// File: rtl/tone_synth.sv
// Phase-accumulator tone generator; the Q16.16 Hz request is turned into a phase
// increment by a bit-serial restoring divider and applied on the next sample tick.
module tone_synth #(
  parameter int SIG_WIDTH   = 9,
  parameter int WIDTH       = 32,
  parameter int DEC_WIDTH   = 16,
  parameter int SAMPLE_RATE = 8000,
  parameter int PHASE_WIDTH = 24,
  parameter int F_MAX       = 1000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  tone_synth_if.slave bus
);
  localparam int SHIFT = PHASE_WIDTH - DEC_WIDTH;
  localparam int NUM_W = WIDTH + SHIFT;
  localparam int CNT_W = $clog2(NUM_W);
  localparam int DIV_W = $clog2(SAMPLE_RATE) + 1;
  localparam int M     = PHASE_WIDTH - 1;
  localparam int S     = SIG_WIDTH;
  localparam logic [WIDTH-1:0] F_CLAMP = WIDTH'(F_MAX) << DEC_WIDTH;
  localparam logic [DIV_W-1:0] DIVISOR = DIV_W'(SAMPLE_RATE);
  localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(NUM_W - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_DIV = 2'd1, ST_DONE = 2'd2} state_t;

  state_t                 state_r, state_s;
  logic [NUM_W-1:0]       num_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [DIV_W-2:0]       rem_r, rem_s;
  logic [DIV_W-1:0]       shift_s;
  logic                   qbit_s;
  logic [PHASE_WIDTH-1:0] quo_r, pend_inc_r, active_inc_r, phase_r, inc_eff_s;
  logic [WIDTH-1:0]       f_c_s;
  logic                   pend_valid_r, f_ready_r, sig_valid_r;
  logic [S-1:0]           sig_r;

  // Top S+1 phase bits select the sample; lower bits only carry the fraction.
  function automatic logic [S-1:0] wave_f(input logic [S:0] top, input logic [1:0] sel);
    logic [S-1:0] t;
    t = top[S-1:0] ^ {S{top[S]}};
    case (sel)
      2'b01:   wave_f = {~t[S-1], t[S-2:0]};
      2'b10:   wave_f = {~top[S], top[S-1:1]};
      default: wave_f = top[S] ? {1'b1, {(S-1){1'b0}}} : {1'b0, {(S-1){1'b1}}};
    endcase
  endfunction

  // Next-state logic of the divider sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.f_in_valid) state_s = ST_DIV;
        else                state_s = ST_IDLE;
      end
      ST_DIV: begin
        if (cnt_r == {CNT_W{1'b0}}) state_s = ST_DONE;
        else                        state_s = ST_DIV;
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // One restoring-division step, request clamp and effective increment.
  always_comb begin
    shift_s = {rem_r, num_r[cnt_r]};
    if (shift_s >= DIVISOR) begin
      rem_s  = (DIV_W-1)'(shift_s - DIVISOR);
      qbit_s = 1'b1;
    end else begin
      rem_s  = shift_s[DIV_W-2:0];
      qbit_s = 1'b0;
    end
    if (bus.f_in > F_CLAMP) f_c_s = F_CLAMP;
    else                    f_c_s = bus.f_in;
    if (pend_valid_r) inc_eff_s = pend_inc_r;
    else              inc_eff_s = active_inc_r;
  end

  // Divider state, operands and pending increment.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_r    <= ST_IDLE;
      f_ready_r  <= 1'b1;
      num_r      <= {NUM_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      rem_r      <= {(DIV_W-1){1'b0}};
      quo_r      <= {PHASE_WIDTH{1'b0}};
      pend_inc_r <= {PHASE_WIDTH{1'b0}};
    end else begin
      state_r   <= state_s;
      f_ready_r <= (state_s == ST_IDLE);
      case (state_r)
        ST_IDLE: begin
          if (bus.f_in_valid) begin
            num_r <= {f_c_s, {SHIFT{1'b0}}};
            cnt_r <= CNT_TOP;
            rem_r <= {(DIV_W-1){1'b0}};
            quo_r <= {PHASE_WIDTH{1'b0}};
          end
        end
        ST_DIV: begin
          rem_r <= rem_s;
          quo_r <= {quo_r[PHASE_WIDTH-2:0], qbit_s};
          cnt_r <= cnt_r - CNT_ONE;
        end
        ST_DONE: pend_inc_r <= quo_r;
        default: ;
      endcase
    end
  end

  // Sample path: increment hand-over, phase accumulation and output sample.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pend_valid_r <= 1'b0;
      active_inc_r <= {PHASE_WIDTH{1'b0}};
      phase_r      <= {PHASE_WIDTH{1'b0}};
      sig_r        <= {S{1'b0}};
      sig_valid_r  <= 1'b0;
    end else begin
      sig_valid_r <= bus.sample_tick_in;
      // A freshly finished divide wins over a tick consuming the older result.
      if (state_r == ST_DONE)      pend_valid_r <= 1'b1;
      else if (bus.sample_tick_in) pend_valid_r <= 1'b0;
      if (bus.sample_tick_in) begin
        active_inc_r <= inc_eff_s;
        if (!bus.enable_in) begin
          sig_r   <= {S{1'b0}};
          phase_r <= {PHASE_WIDTH{1'b0}};
        end else if (inc_eff_s == {PHASE_WIDTH{1'b0}}) begin
          sig_r   <= {S{1'b0}};
        end else begin
          sig_r   <= wave_f(phase_r[M -: S+1], bus.wave_sel_in);
          phase_r <= phase_r + inc_eff_s;
        end
      end
    end
  end

  assign bus.f_ready_out   = f_ready_r;
  assign bus.sig_out       = sig_r;
  assign bus.sig_out_valid = sig_valid_r;
endmodule

// File: doc/tone_synth.md
# tone_synth

Digital tone generator producing a periodic waveform at a requested pitch, one sample per sample strobe at SAMPLE_RATE. It is the inverse of the pitch detector. It takes a frequency in the detector's unsigned Q16.16 Hz format and emits signed samples in the detector's sample width, so synthesized tones can be fed straight back into the detector for loopback self-test. Frequency changes are phase-continuous and take effect on a sample boundary.

## Interface
- SIG_WIDTH, 9, sample width (two's complement)
- WIDTH, 32, frequency word width
- DEC_WIDTH, 16, fractional bits of frequency word
- SAMPLE_RATE, 8000, output sample rate in Hz
- PHASE_WIDTH, 24, phase accumulator width (must exceed SIG_WIDTH+1)
- F_MAX, 1000, clamp frequency in Hz (integer)
- clk_in  input  1  system clock
- rst_in  input  1  reset, synchronous, active-low
- f_in  input  WIDTH  requested frequency, unsigned Q(WIDTH-DEC_WIDTH).DEC_WIDTH Hz
- f_in_valid  input  1  frequency strobe; accepted only when f_ready_out=1
- f_ready_out  output  1  block can accept a new frequency
- sample_tick_in  input  1  single-cycle strobe at SAMPLE_RATE
- enable_in  input  1  0 = mute and hold phase at 0
- wave_sel_in  input  2  00 square, 01 triangle, 10 sawtooth, 11 treated as square
- sig_out  output  SIG_WIDTH  current sample, two's complement
- sig_out_valid  output  1  one-cycle pulse per produced sample

## Operation
- Clock is clk_in only. Reset is synchronous, active-low on rst_in.
- Phase increment: inc = floor((f_c << (PHASE_WIDTH-DEC_WIDTH)) / SAMPLE_RATE), where f_c = min(f_in, F_MAX<<DEC_WIDTH).
- Numerator width is NUM_W = WIDTH+PHASE_WIDTH-DEC_WIDTH (40 by default). The result is truncated to PHASE_WIDTH bits.
- Division is an internal restoring divider producing 1 quotient bit per cycle, NUM_W cycles. No external divider is instantiated.
- FSM states:
  - IDLE: f_ready_out=1. f_in_valid latches f_c and moves to DIVIDING.
  - DIVIDING: bit counter runs from NUM_W-1 down to 0. At 0, moves to DONE.
  - DONE: writes pend_inc, sets pend_valid, returns to IDLE.
- On sample_tick_in:
  - If pend_valid, active_inc <= pend_inc and pend_valid is cleared. The new inc is used from this tick's phase update onward.
  - If enable_in=1: sig_out <= wave(phase), then phase <= phase + active_inc, mod 2^PHASE_WIDTH.
  - If enable_in=0: sig_out <= 0 and phase <= 0.
- Muting: if active_inc == 0, sig_out <= 0 regardless of wave_sel_in, and phase is unchanged.
- Waveforms, with p = phase, M = PHASE_WIDTH-1, S = SIG_WIDTH:
  - square: p[M]=0 gives 2^(S-1)-1, else -2^(S-1).
  - sawtooth: {~p[M], p[M-1 -: S-1]}, rising from -2^(S-1).
  - triangle: t = p[M] ? ~p[M-1 -: S] : p[M-1 -: S], and sig = {~t[S-1], t[S-2:0]}. Phase 0 gives -2^(S-1); phase half-way gives 2^(S-1)-1.
- f_in_valid while f_ready_out=0 is ignored (no queueing).
- A second accepted frequency before pend is consumed overwrites pend_inc.

## Timing
- Reset values: sig_out=0, sig_out_valid=0, f_ready_out=1, phase=0, active_inc=0, pend_valid=0, state IDLE.
- Frequency accepted at edge k:
  - f_ready_out is 0 from k+1 through k+NUM_W+1.
  - f_ready_out is 1 again at k+NUM_W+2, with pend_valid=1 at that point.
- Sample tick at edge t:
  - sig_out updates at t+1.
  - sig_out_valid=1 for exactly the cycle after t, including when muted or disabled.
  - The sample value is computed from the phase before the increment.
- sample_tick_in during DIVIDING uses the old active_inc.
- sample_tick_in in the same cycle as DONE uses the old inc. The new inc applies at the next tick.
- Reset asserted mid-divide aborts the divide; the partial result is discarded.
- Throughput: sample_tick_in spacing must be at least 1 cycle; back-to-back ticks each produce a sample.

## Test plan
- Reset, then 3 ticks with no frequency: f_ready_out=1, three sig_out_valid pulses, sig_out=0 each time.
- f_in=0x03E8_0000 (1000 Hz), square, enable=1:
  - f_ready_out low for 41 cycles.
  - inc=0x200000.
  - Sample sequence repeats every 8 ticks: 255×4, -256×4.
- f_in=0x01F4_0000 (500 Hz), sawtooth:
  - inc=0x100000.
  - First samples -256, -224, -192, … step +32, period 16.
- f_in=0x01B8_0000 (440 Hz): internal inc=922746 (0x0E147A). Triangle output has min -256 and max within 255-8 of 255.
- f_in=0x07D0_0000 (2000 Hz): clamped, inc=0x200000. A second f_in_valid during DIVIDING is ignored, and f_ready_out stays low.
- Mid-stream enable_in=0 for 2 ticks: sig_out=0 on both. After re-enable, the first sample equals wave(0) (-256 for sawtooth).
- Reset during DIVIDING: all outputs return to reset values, and the next tick gives sig_out=0.
